// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues one outstanding imem read at a time for
// the current PC, buffers returned words with their PC+4 in a small FIFO, and
// holds the PC until each fetch is granted. A flush empties the FIFO and
// discards any response still in flight.
//
// Handshakes:
//   imem side : a request is transferred in a cycle where imem_req_o and
//               imem_gnt_i are both 1; imem_addr_o is held stable until then.
//               Exactly one imem_rvalid_i answers each transfer.
//   IF/ID side: the head entry is transferred in a cycle where inst_valid_o
//               and id_ready_i are both 1; inst_o/inst_pc4_o stay stable
//               while inst_valid_o is 1 and the head is not taken.
module if_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pc_hold_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc4_o,
    input  logic        id_ready_i,
    output logic [1:0]  dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e             state_q;
    logic [31:0]        addr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   fill_q;
    logic [31:0]        inst_mem_q [DEPTH];
    logic [31:0]        pc4_mem_q  [DEPTH];

    logic [CNT_W-1:0]   credit_cnt;
    logic               grant;
    logic               push;
    logic               pop;

    // Occupancy used for issue decisions: stored entries plus the slot
    // reserved for a response still outstanding.
    assign credit_cnt = fill_q + {{(CNT_W-1){1'b0}}, (state_q == S_WAIT)};

    // Request/hold decode; flush overrides so the PC can load its redirect.
    always_comb begin
        imem_req_o = 1'b0;
        pc_hold_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                imem_req_o = 1'b0;
                pc_hold_o  = 1'b0;
            end
            S_REQ: begin
                imem_req_o = start_i && !flush_i && (credit_cnt < CNT_W'(DEPTH));
                pc_hold_o  = !(imem_req_o && imem_gnt_i);
            end
            default: begin
                imem_req_o = 1'b0;
                pc_hold_o  = 1'b1;
            end
        endcase
        if (flush_i) begin
            imem_req_o = 1'b0;
            pc_hold_o  = 1'b0;
        end
    end

    assign imem_addr_o = imem_req_o ? pc_i : 32'h0;
    assign grant       = imem_req_o && imem_gnt_i;
    assign push        = (state_q == S_WAIT) && imem_rvalid_i && !flush_i;
    assign pop         = inst_valid_o && id_ready_i && !flush_i;

    // Fetch sequencer: one outstanding read, DROP swallows a flushed response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) state_q <= S_REQ;
                end
                S_REQ: begin
                    if (flush_i) begin
                        state_q <= S_REQ;
                    end else if (!start_i) begin
                        state_q <= S_IDLE;
                    end else if (grant) begin
                        addr_q  <= pc_i;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= (flush_i || start_i) ? S_REQ : S_IDLE;
                    end else if (flush_i) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i) state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and fill level; flush clears everything at the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill_q <= fill_q + CNT_W'(1);
                2'b01:   fill_q <= fill_q - CNT_W'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // FIFO storage; PC+4 wraps naturally in 32 bits.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc4_mem_q[wr_ptr_q]  <= addr_q + 32'd4;
        end
    end

    assign inst_valid_o = (fill_q != '0);
    assign inst_o       = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign inst_pc4_o   = inst_valid_o ? pc4_mem_q[rd_ptr_q]  : 32'h0;
    assign dbg_state_o  = state_q;

endmodule
